// File: rtl/sc_clk_pkg.sv
// Shared types and helpers for the two-phase switched-capacitor clock generator.
package sc_clk_pkg;

  localparam int DEF_CNT_W  = 8;
  localparam int DEF_PCNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    PHI1,
    GAP12,
    PHI2,
    GAP21
  } sc_phase_e;

  // Phase and gap lengths of zero are promoted to one cycle so that the
  // dead time can never collapse and every state lasts at least one cycle.
  function automatic logic [31:0] clamp1(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/sc_phase_timer.sv
// Loadable down-counter shared by all timed phases; expire flags the last
// cycle of the current phase (count == 1).
module sc_phase_timer
  import sc_clk_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  // Load on phase entry, otherwise count down and hold at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= CNT_W'(1);
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt > CNT_W'(1)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/sc_phase_gen.sv
// Two-phase non-overlapping clock generator for the switched-capacitor
// filter. phi1/phi2 are registered decodes of the phase state, so they trail
// the state by one cycle and can never be high together.
module sc_phase_gen
  import sc_clk_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int PCNT_W = DEF_PCNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  phi1_len,
  input  logic [CNT_W-1:0]  phi2_len,
  input  logic [CNT_W-1:0]  dead_len,
  output logic              phi1,
  output logic              phi2,
  output logic              period_done,
  output logic [PCNT_W-1:0] period_cnt,
  output logic              busy
);

  sc_phase_e        st, st_nxt;
  logic [CNT_W-1:0] l1_in, l2_in, d_in;
  logic [CNT_W-1:0] l2_q, d_q;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_load, tmr_expire;
  logic             stop_q, stop;
  logic             ent_q;

  assign l1_in = CNT_W'(clamp1(32'(phi1_len)));
  assign l2_in = CNT_W'(clamp1(32'(phi2_len)));
  assign d_in  = CNT_W'(clamp1(32'(dead_len)));

  // Once en is seen low the run is winding down; a re-assert is ignored
  // until IDLE has been reached.
  assign stop = stop_q | ~en;

  // Next-state logic; truncated phases still pass through a full gap.
  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (en) st_nxt = PHI1;
      PHI1:    if (stop || tmr_expire) st_nxt = GAP12;
      GAP12:   if (tmr_expire) st_nxt = stop ? IDLE : PHI2;
      PHI2:    if (stop || tmr_expire) st_nxt = GAP21;
      GAP21:   if (tmr_expire) st_nxt = stop ? IDLE : PHI1;
      default: st_nxt = IDLE;
    endcase
  end

  // Timer reload value for the state being entered. L1 is taken straight
  // from the input because it is captured on the same edge PHI1 is entered;
  // the timer itself holds it for the rest of the phase.
  always_comb begin
    tmr_load = (st_nxt != st);
    tmr_val  = CNT_W'(1);
    case (st_nxt)
      PHI1:          tmr_val = l1_in;
      GAP12, GAP21:  tmr_val = d_q;
      PHI2:          tmr_val = l2_q;
      default:       tmr_val = CNT_W'(1);
    endcase
  end

  sc_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // State register, stop flag, first-cycle flag and per-period config capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      stop_q <= 1'b0;
      ent_q  <= 1'b0;
      l2_q   <= CNT_W'(1);
      d_q    <= CNT_W'(1);
    end else begin
      st     <= st_nxt;
      stop_q <= (st != IDLE && st_nxt != IDLE) ? stop : 1'b0;
      ent_q  <= tmr_load;
      if (st_nxt == PHI1 && st != PHI1) begin
        l2_q <= l2_in;
        d_q  <= d_in;
      end
    end
  end

  // Registered outputs; a completed period is the first cycle of GAP21.
  always_ff @(posedge clk) begin
    if (rst) begin
      phi1        <= 1'b0;
      phi2        <= 1'b0;
      busy        <= 1'b0;
      period_done <= 1'b0;
      period_cnt  <= '0;
    end else begin
      phi1        <= (st == PHI1);
      phi2        <= (st == PHI2);
      busy        <= (st != IDLE);
      period_done <= (st == GAP21) && ent_q;
      if ((st == GAP21) && ent_q) period_cnt <= period_cnt + PCNT_W'(1);
    end
  end

endmodule
